// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver pair: parity encodings,
// transmit FSM state encoding and the bit-period helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Truncating divide: the line runs slightly fast when the ratio is not integral.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: reloads on i_reload and pulses o_bit_end in the last clk
// cycle of every CLKS_PER_BIT-cycle period while i_en is high.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic i_reload,
  input  logic i_en,
  output logic o_bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_zero;

  assign w_zero    = (r_cnt == '0);
  assign o_bit_end = i_en & w_zero & ~i_reload;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_reload) begin
      r_cnt <= C_RELOAD;
    end else if (i_en) begin
      if (w_zero) begin
        r_cnt <= C_RELOAD;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake, sent as start, data
// (LSB first), optional parity and stop bits. UART_TX_CTS_EN adds cts_n gating.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY_BIT = 2,
  parameter int DATA_LEN   = 8,
  parameter int STOP_BIT   = 1,
  parameter int CLK_FREQ   = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_LEN-1:0] in_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx,
  output logic                busy,
`ifdef UART_TX_CTS_EN
  input  logic                cts_n,
`endif
  output logic [2:0]          state
);

  // Handshake: a word is taken on any clk edge where tx_valid and tx_ready are
  // both high; tx_valid is don't-care while tx_ready is low.

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BW  = $clog2(DATA_LEN + 1);
  localparam logic [BW-1:0] C_DLEN = BW'(DATA_LEN);
  localparam logic [BW-1:0] C_STOP = BW'(STOP_BIT);
  localparam logic [BW-1:0] C_ONE  = BW'(1);

  logic [2:0]          r_state;
  logic [DATA_LEN-1:0] r_shift;
  logic                r_parity;
  logic                r_tx;
  logic [BW-1:0]       r_bit_cnt;

  logic w_idle;
  logic w_accept;
  logic w_bit_end;
  logic w_parity;

  assign w_idle = (r_state == ST_IDLE);

`ifdef UART_TX_CTS_EN
  assign tx_ready = w_idle & ~cts_n;
`else
  assign tx_ready = w_idle;
`endif

  assign w_accept = tx_valid & tx_ready;
  assign busy     = ~w_idle;
  assign tx       = r_tx;
  assign state    = r_state;

  assign w_parity = (PARITY_BIT == PARITY_ODD) ? ~(^in_data) : (^in_data);

  uart_baud_tick #(
    .CLKS_PER_BIT (CPB)
  ) u_baud_tick (
    .clk       (clk),
    .rst       (rst),
    .i_reload  (w_accept),
    .i_en      (~w_idle),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_shift   <= in_data;
            r_parity  <= w_parity;
            r_tx      <= 1'b0;
            r_bit_cnt <= '0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= C_ONE;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == C_DLEN) begin
              // r_bit_cnt is reused to count stop-bit periods
              r_bit_cnt <= C_ONE;
              if (PARITY_BIT != PARITY_NONE) begin
                r_tx    <= r_parity;
                r_state <= ST_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_tx      <= 1'b1;
            r_bit_cnt <= C_ONE;
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            if (r_bit_cnt == C_STOP) begin
              r_bit_cnt <= '0;
              r_state   <= ST_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_tx      <= 1'b1;
          r_bit_cnt <= '0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
